// File: rtl/pwu_pkg.sv
// Shared constants and the round-robin walker picker for the page-walk dispatcher.
package pwu_pkg;

  localparam int PWU_DEF_NUM_WALKERS = 4;
  localparam int PWU_DEF_VA_W        = 32;
  localparam int PWU_DEF_PA_W        = 28;
  localparam int PWU_MAX_WALKERS     = 16;

  typedef logic [PWU_MAX_WALKERS-1:0] wk_mask_t;
  typedef logic [3:0]                 wk_id_t;

  // First set bit of free at or after ptr, wrapping modulo n; returns ptr when none is set.
  function automatic int rr_pick(input wk_mask_t free, input int ptr, input int n);
    wk_id_t idx;
    rr_pick = ptr;
    for (int i = PWU_MAX_WALKERS-1; i >= 0; i--) begin
      if (i < n) begin
        idx = wk_id_t'((ptr + i) % n);
        if (free[idx]) rr_pick = int'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/pwu_ord_fifo.sv
// Issue-order FIFO of walker IDs; depth is a power of two so pointers wrap naturally.
module pwu_ord_fifo #(
  parameter int DEPTH = 4,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          clr_i,
  input  logic          push_i,
  input  logic [IW-1:0] id_i,
  input  logic          pop_i,
  output logic [IW-1:0] head_o,
  output logic          empty_o,
  output logic          full_o
);

  localparam logic [IW:0] FULL_CNT = DEPTH[IW:0];

  logic [DEPTH-1:0][IW-1:0] mem;
  logic [IW-1:0]            wr_ptr, rd_ptr;
  logic [IW:0]              cnt;
  logic                     do_push, do_pop;

  assign do_push = push_i & ~full_o & ~clr_i;
  assign do_pop  = pop_i & ~empty_o & ~clr_i;
  assign head_o  = mem[rd_ptr];
  assign empty_o = (cnt == '0);
  assign full_o  = (cnt == FULL_CNT);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + IW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + IW'(1);
      cnt <= cnt + (IW+1)'(do_push) - (IW+1)'(do_pop);
    end
  end

  // Storage needs no reset: head is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= id_i;
  end

endmodule

// File: rtl/pwu_dispatch.sv
// Page-walker dispatcher: round-robin issue to free walkers, in-order retire of PAs.
// Optional perf counters are built when PWU_PERF_CNT_EN is defined.
module pwu_dispatch
  import pwu_pkg::*;
#(
  parameter int NUM_WALKERS = PWU_DEF_NUM_WALKERS,
  parameter int VA_W        = PWU_DEF_VA_W,
  parameter int PA_W        = PWU_DEF_PA_W
`ifdef PWU_PERF_CNT_EN
  ,
  parameter int CNT_W       = 32
`endif
) (
  input  logic                        clk_i,
  input  logic                        resetn_i,
  input  logic [VA_W-1:0]             va_i,
  input  logic                        va_vld_i,
  output logic                        va_rdy_o,
  input  logic                        flush_i,
  output logic [VA_W-1:0]             wk_va_o,
  output logic [NUM_WALKERS-1:0]      wk_start_o,
  input  logic [NUM_WALKERS-1:0]      wk_idle_i,
  input  logic [NUM_WALKERS-1:0]      wk_done_i,
  input  logic [NUM_WALKERS*PA_W-1:0] wk_pa_i,
  input  logic [NUM_WALKERS-1:0]      wk_fault_i,
  output logic [NUM_WALKERS-1:0]      wk_ack_o,
  output logic [NUM_WALKERS-1:0]      wk_kill_o,
  output logic [PA_W-1:0]             pa_o,
  output logic                        pa_fault_o,
  output logic                        pa_vld_o,
  input  logic                        pa_rdy_i
`ifdef PWU_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]            perf_xlat_o,
  output logic [CNT_W-1:0]            perf_fault_o,
  output logic [CNT_W-1:0]            perf_stall_o
`endif
);

  localparam int IW = $clog2(NUM_WALKERS);

  logic [NUM_WALKERS-1:0]           busy_q, free;
  logic [IW-1:0]                    rr_ptr, sel, head;
  logic                             ord_empty, ord_full, fire, ret;
  logic [NUM_WALKERS-1:0][PA_W-1:0] pa_lane;

  assign pa_lane  = wk_pa_i;
  assign wk_va_o  = va_i;
  assign free     = wk_idle_i & ~busy_q;
  assign va_rdy_o = (|free) & ~ord_full & ~flush_i;
  assign fire     = va_vld_i & va_rdy_o;
  assign sel      = IW'(rr_pick(wk_mask_t'(free), int'(rr_ptr), NUM_WALKERS));
  // Only the oldest walker may retire; a downstream slot frees up on the same cycle it drains.
  assign ret      = ~flush_i & ~ord_empty & wk_done_i[head] & (~pa_vld_o | pa_rdy_i);

  always_comb begin
    wk_start_o = '0;
    wk_ack_o   = '0;
    wk_kill_o  = '0;
    if (flush_i) begin
      wk_kill_o = busy_q;
    end else begin
      if (fire) wk_start_o[sel] = 1'b1;
      if (ret)  wk_ack_o[head]  = 1'b1;
    end
  end

  pwu_ord_fifo #(
    .DEPTH (NUM_WALKERS),
    .IW    (IW)
  ) u_ord (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clr_i    (flush_i),
    .push_i   (fire),
    .id_i     (sel),
    .pop_i    (ret),
    .head_o   (head),
    .empty_o  (ord_empty),
    .full_o   (ord_full)
  );

  // A walker acked this cycle becomes selectable only after busy_q clears at the edge.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      busy_q     <= '0;
      rr_ptr     <= '0;
      pa_o       <= '0;
      pa_fault_o <= 1'b0;
      pa_vld_o   <= 1'b0;
    end else if (flush_i) begin
      busy_q   <= '0;
      pa_vld_o <= 1'b0;
    end else begin
      busy_q <= (busy_q | wk_start_o) & ~wk_ack_o;
      if (fire) rr_ptr <= sel + IW'(1);
      if (ret) begin
        pa_o       <= pa_lane[head];
        pa_fault_o <= wk_fault_i[head];
        pa_vld_o   <= 1'b1;
      end else if (pa_rdy_i) begin
        pa_vld_o <= 1'b0;
      end
    end
  end

`ifdef PWU_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      perf_xlat_o  <= '0;
      perf_fault_o <= '0;
      perf_stall_o <= '0;
    end else begin
      if (pa_vld_o & pa_rdy_i)              perf_xlat_o  <= perf_xlat_o + CNT_W'(1);
      if (pa_vld_o & pa_rdy_i & pa_fault_o) perf_fault_o <= perf_fault_o + CNT_W'(1);
      if (va_vld_i & ~va_rdy_o)             perf_stall_o <= perf_stall_o + CNT_W'(1);
    end
  end
`endif

endmodule
